// File: rtl/btb_update_ctrl.sv
// 8-entry branch target buffer update controller: hit/allocate/replace with
// 2-bit saturating counters, round-robin replacement when the table is full.
module btb_update_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken,
   input  logic        clr,
   output logic        v1, v2, v3, v4, v5, v6, v7, v8,
   output logic [31:0] A1, A2, A3, A4, A5, A6, A7, A8,
   output logic [31:0] B1, B2, B3, B4, B5, B6, B7, B8,
   output logic [1:0]  s1, s2, s3, s4, s5, s6, s7, s8,
   output logic [15:0] upd_cnt,
   output logic [15:0] evict_cnt
);
   logic [7:0]        v_q, v_d;
   logic [7:0][31:0]  a_q, a_d, b_q, b_d;
   logic [7:0][1:0]   s_q, s_d;
   logic [2:0]        ptr_q, ptr_d;
   logic [15:0]       upd_cnt_q, upd_cnt_d, evict_cnt_q, evict_cnt_d;

   logic       hit, free;
   logic [2:0] hit_idx, free_idx, alloc_idx;

   always_comb begin
      hit      = 1'b0;
      hit_idx  = 3'd0;
      free     = 1'b0;
      free_idx = 3'd0;
      // descending scan so the lowest matching index is the one left standing
      for (int i = 7; i >= 0; i--) begin
         if (v_q[i] && a_q[i] == upd_pc) begin
            hit     = 1'b1;
            hit_idx = 3'(i);
         end
         if (!v_q[i]) begin
            free     = 1'b1;
            free_idx = 3'(i);
         end
      end
      alloc_idx = free ? free_idx : ptr_q;
   end

   always_comb begin
      v_d         = v_q;
      a_d         = a_q;
      b_d         = b_q;
      s_d         = s_q;
      ptr_d       = ptr_q;
      upd_cnt_d   = upd_cnt_q;
      evict_cnt_d = evict_cnt_q;
      if (clr) begin
         v_d   = '0;
         ptr_d = '0;
      end else if (upd_valid) begin
         upd_cnt_d = upd_cnt_q + 16'd1;
         if (hit) begin
            if (upd_taken) begin
               if (s_q[hit_idx] != 2'd3) s_d[hit_idx] = s_q[hit_idx] + 2'd1;
               b_d[hit_idx] = upd_target;
            end else if (s_q[hit_idx] != 2'd0) begin
               s_d[hit_idx] = s_q[hit_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            v_d[alloc_idx] = 1'b1;
            a_d[alloc_idx] = upd_pc;
            b_d[alloc_idx] = upd_target;
            s_d[alloc_idx] = 2'b10;
            if (!free) begin
               ptr_d       = ptr_q + 3'd1;
               evict_cnt_d = evict_cnt_q + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         s_q         <= '0;
         ptr_q       <= '0;
         upd_cnt_q   <= '0;
         evict_cnt_q <= '0;
      end else begin
         v_q         <= v_d;
         a_q         <= a_d;
         b_q         <= b_d;
         s_q         <= s_d;
         ptr_q       <= ptr_d;
         upd_cnt_q   <= upd_cnt_d;
         evict_cnt_q <= evict_cnt_d;
      end
   end

   assign {v8, v7, v6, v5, v4, v3, v2, v1} = v_q;
   assign {A8, A7, A6, A5, A4, A3, A2, A1} = a_q;
   assign {B8, B7, B6, B5, B4, B3, B2, B1} = b_q;
   assign {s8, s7, s6, s5, s4, s3, s2, s1} = s_q;
   assign upd_cnt   = upd_cnt_q;
   assign evict_cnt = evict_cnt_q;
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Self-checking bench for btb_update_ctrl: directed scenarios plus a randomized
// run against a table model kept as plain arrays.
module tb_btb_update_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0, clr = 1'b0;
   logic [31:0] upd_pc = '0, upd_target = '0;
   logic        v1, v2, v3, v4, v5, v6, v7, v8;
   logic [31:0] A1, A2, A3, A4, A5, A6, A7, A8;
   logic [31:0] B1, B2, B3, B4, B5, B6, B7, B8;
   logic [1:0]  s1, s2, s3, s4, s5, s6, s7, s8;
   logic [15:0] upd_cnt, evict_cnt;

   int checks = 0, failures = 0;

   btb_update_ctrl dut (
      .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_target(upd_target), .upd_taken(upd_taken), .clr(clr),
      .v1(v1), .v2(v2), .v3(v3), .v4(v4), .v5(v5), .v6(v6), .v7(v7), .v8(v8),
      .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5), .A6(A6), .A7(A7), .A8(A8),
      .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5), .B6(B6), .B7(B7), .B8(B8),
      .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5), .s6(s6), .s7(s7), .s8(s8),
      .upd_cnt(upd_cnt), .evict_cnt(evict_cnt)
   );

   always #5 clk = ~clk;

   logic [7:0]  dv;
   logic [31:0] da [8];
   logic [31:0] db [8];
   logic [1:0]  ds [8];
   assign dv = {v8, v7, v6, v5, v4, v3, v2, v1};
   assign da[0] = A1; assign da[1] = A2; assign da[2] = A3; assign da[3] = A4;
   assign da[4] = A5; assign da[5] = A6; assign da[6] = A7; assign da[7] = A8;
   assign db[0] = B1; assign db[1] = B2; assign db[2] = B3; assign db[3] = B4;
   assign db[4] = B5; assign db[5] = B6; assign db[6] = B7; assign db[7] = B8;
   assign ds[0] = s1; assign ds[1] = s2; assign ds[2] = s3; assign ds[3] = s4;
   assign ds[4] = s5; assign ds[5] = s6; assign ds[6] = s7; assign ds[7] = s8;

   // reference table
   bit          m_v [8];
   logic [31:0] m_a [8];
   logic [31:0] m_b [8];
   int          m_s [8];
   int          m_ptr, m_upd, m_ev;

   function automatic void model_step(bit r, bit c, bit vl, logic [31:0] pc,
                                      logic [31:0] tg, bit tk);
      int h, f;
      if (r) begin
         for (int i = 0; i < 8; i++) begin
            m_v[i] = 0; m_a[i] = 0; m_b[i] = 0; m_s[i] = 0;
         end
         m_ptr = 0; m_upd = 0; m_ev = 0;
         return;
      end
      if (c) begin
         for (int i = 0; i < 8; i++) m_v[i] = 0;
         m_ptr = 0;
         return;
      end
      if (!vl) return;
      m_upd = (m_upd + 1) % 65536;
      h = -1;
      for (int i = 7; i >= 0; i--) if (m_v[i] && m_a[i] == pc) h = i;
      if (h >= 0) begin
         if (tk) begin
            m_s[h] = (m_s[h] == 3) ? 3 : m_s[h] + 1;
            m_b[h] = tg;
         end else m_s[h] = (m_s[h] == 0) ? 0 : m_s[h] - 1;
      end else if (tk) begin
         f = -1;
         for (int i = 7; i >= 0; i--) if (!m_v[i]) f = i;
         if (f < 0) begin
            f = m_ptr;
            m_ptr = (m_ptr + 1) % 8;
            m_ev = (m_ev + 1) % 65536;
         end
         m_v[f] = 1; m_a[f] = pc; m_b[f] = tg; m_s[f] = 2;
      end
   endfunction

   task automatic do_cyc(bit r, bit c, bit vl, logic [31:0] pc, logic [31:0] tg, bit tk);
      rst = r; clr = c; upd_valid = vl; upd_pc = pc; upd_target = tg; upd_taken = tk;
      @(posedge clk);
      model_step(r, c, vl, pc, tg, tk);
      #1;
      rst = 0; clr = 0; upd_valid = 0;
      upd_pc = $urandom; upd_target = $urandom; upd_taken = 1'($urandom);
   endtask

   task automatic test_reset();
      do_cyc(1, 0, 0, 0, 0, 0);
      checks++;
      if (dv !== 8'h00 || upd_cnt !== 16'd0 || evict_cnt !== 16'd0 ||
          A1 !== 32'd0 || B8 !== 32'd0 || s4 !== 2'd0) begin
         failures++;
         $display("FAIL reset: v=%h upd=%0d ev=%0d A1=%h B8=%h s4=%0d want all 0",
                  dv, upd_cnt, evict_cnt, A1, B8, s4);
      end
   endtask

   task automatic test_alloc();
      do_cyc(0, 0, 1, 32'h40, 32'h100, 1);
      checks++;
      if (dv !== 8'h01 || A1 !== 32'h40 || B1 !== 32'h100 || s1 !== 2'd2 || upd_cnt !== 16'd1) begin
         failures++;
         $display("FAIL alloc: v=%h A1=%h B1=%h s1=%0d upd=%0d want 01/40/100/2/1",
                  dv, A1, B1, s1, upd_cnt);
      end
   endtask

   task automatic test_saturation();
      int exp_s [6] = '{3, 3, 2, 1, 0, 0};
      for (int k = 0; k < 6; k++) begin
         do_cyc(0, 0, 1, 32'h40, (k < 2) ? 32'h100 : 32'hDEAD0000, (k < 2));
         checks++;
         if (s1 !== 2'(exp_s[k]) || v1 !== 1'b1 || B1 !== 32'h100) begin
            failures++;
            $display("FAIL saturation step %0d: s1=%0d v1=%b B1=%h want %0d/1/100",
                     k, s1, v1, B1, exp_s[k]);
         end
      end
   endtask

   task automatic test_replacement();
      do_cyc(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++) do_cyc(0, 0, 1, 32'(k * 4), 32'(32'h1000 + k), 1);
      checks++;
      if (dv !== 8'hFF || evict_cnt !== 16'd0) begin
         failures++;
         $display("FAIL fill: v=%h ev=%0d want ff/0", dv, evict_cnt);
      end
      do_cyc(0, 0, 1, 32'h20, 32'h2000, 1);
      checks++;
      if (A1 !== 32'h20 || B1 !== 32'h2000 || evict_cnt !== 16'd1 || A2 !== 32'h04) begin
         failures++;
         $display("FAIL first_evict: A1=%h B1=%h ev=%0d A2=%h want 20/2000/1/4",
                  A1, B1, evict_cnt, A2);
      end
      for (int k = 0; k < 8; k++) do_cyc(0, 0, 1, 32'(32'h24 + k * 4), 32'h3000, 1);
      checks++;
      if (A1 !== 32'h40 || A2 !== 32'h24 || A8 !== 32'h3C || evict_cnt !== 16'd9) begin
         failures++;
         $display("FAIL ptr_wrap: A1=%h A2=%h A8=%h ev=%0d want 40/24/3c/9",
                  A1, A2, A8, evict_cnt);
      end
      do_cyc(0, 0, 1, 32'h44, 32'h4400, 1);
      checks++;
      if (A2 !== 32'h44 || A1 !== 32'h40 || evict_cnt !== 16'd10 || upd_cnt !== 16'd18) begin
         failures++;
         $display("FAIL ptr_after_wrap: A2=%h A1=%h ev=%0d upd=%0d want 44/40/10/18",
                  A2, A1, evict_cnt, upd_cnt);
      end
   endtask

   task automatic test_miss_not_taken();
      bit bad = 0;
      do_cyc(0, 0, 1, 32'h80, 32'h8000, 0);
      for (int i = 0; i < 8; i++)
         if (dv[i] !== m_v[i] || da[i] !== m_a[i] || db[i] !== m_b[i] || ds[i] !== 2'(m_s[i])) bad = 1;
      checks++;
      if (bad || upd_cnt !== 16'd19 || evict_cnt !== 16'd10 || dv !== 8'hFF) begin
         failures++;
         $display("FAIL miss_nt: table_diff=%b upd=%0d ev=%0d v=%h want 0/19/10/ff",
                  bad, upd_cnt, evict_cnt, dv);
      end
   endtask

   task automatic test_clear();
      do_cyc(0, 1, 1, 32'h90, 32'h9000, 1);
      checks++;
      if (dv !== 8'h00 || upd_cnt !== 16'd19 || A2 !== 32'h44) begin
         failures++;
         $display("FAIL clr_vs_upd: v=%h upd=%0d A2=%h want 00/19/44", dv, upd_cnt, A2);
      end
      do_cyc(0, 0, 1, 32'h94, 32'h9400, 1);
      checks++;
      if (dv !== 8'h01 || A1 !== 32'h94 || s1 !== 2'd2) begin
         failures++;
         $display("FAIL clr_realloc: v=%h A1=%h s1=%0d want 01/94/2", dv, A1, s1);
      end
      for (int k = 1; k < 8; k++) do_cyc(0, 0, 1, 32'(32'h94 + k * 4), 32'h9500, 1);
      do_cyc(0, 0, 1, 32'hB4, 32'hB400, 1);
      checks++;
      if (A1 !== 32'hB4 || A2 !== 32'h98 || evict_cnt !== 16'd11) begin
         failures++;
         $display("FAIL clr_ptr: A1=%h A2=%h ev=%0d want b4/98/11", A1, A2, evict_cnt);
      end
   endtask

   task automatic test_reset_mid();
      do_cyc(0, 0, 1, 32'hC0, 32'hC000, 1);
      do_cyc(1, 1, 1, 32'hC4, 32'hC400, 1);
      checks++;
      if (dv !== 8'h00 || upd_cnt !== 16'd0 || evict_cnt !== 16'd0 ||
          A1 !== 32'd0 || B1 !== 32'd0 || s1 !== 2'd0 || A8 !== 32'd0) begin
         failures++;
         $display("FAIL reset_mid: v=%h upd=%0d ev=%0d A1=%h B1=%h s1=%0d A8=%h want all 0",
                  dv, upd_cnt, evict_cnt, A1, B1, s1, A8);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         bit bad = 0;
         bit r  = ($urandom_range(0, 99) == 0);
         bit c  = ($urandom_range(0, 29) == 0);
         bit vl = ($urandom_range(0, 3) != 0);
         do_cyc(r, c, vl, {26'd0, 4'($urandom_range(0, 11)), 2'b00}, $urandom, 1'($urandom));
         for (int i = 0; i < 8; i++)
            if (dv[i] !== m_v[i] || da[i] !== m_a[i] || db[i] !== m_b[i] || ds[i] !== 2'(m_s[i])) begin
               bad = 1;
               $display("FAIL random[%0d] entry %0d: v=%b A=%h B=%h s=%0d want v=%b A=%h B=%h s=%0d",
                        n, i + 1, dv[i], da[i], db[i], ds[i], m_v[i], m_a[i], m_b[i], m_s[i]);
            end
         if (upd_cnt !== 16'(m_upd) || evict_cnt !== 16'(m_ev)) begin
            bad = 1;
            $display("FAIL random[%0d] counters: upd=%0d ev=%0d want %0d/%0d",
                     n, upd_cnt, evict_cnt, m_upd, m_ev);
         end
         checks++;
         if (bad) failures++;
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_alloc();
      test_saturation();
      test_replacement();
      test_miss_not_taken();
      test_clear();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/btb_update_ctrl.md
BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port upd_valid, input, 1 bit: a resolved branch/jump update is presented this cycle.
REQ-004 SHALL have port upd_pc, input, 32 bits: PC of the resolved instruction.
REQ-005 SHALL have port upd_target, input, 32 bits: resolved target address.
REQ-006 SHALL have port upd_taken, input, 1 bit: resolved outcome (1 = taken).
REQ-007 SHALL have port clr, input, 1 bit: synchronous table invalidate.
REQ-008 SHALL have ports v1..v8, outputs, 1 bit each: entry valid flags.
REQ-009 SHALL have ports A1..A8, outputs, 32 bits each: entry tag PCs.
REQ-010 SHALL have ports B1..B8, outputs, 32 bits each: entry target addresses.
REQ-011 SHALL have ports s1..s8, outputs, 2 bits each: entry 2-bit saturating counters; a value of 2 or more means predict taken.
REQ-012 SHALL have port upd_cnt, output, 16 bits: count of accepted updates.
REQ-013 SHALL have port evict_cnt, output, 16 bits: count of valid-entry replacements.

Function
REQ-014 SHALL drive all outputs directly from registers, with no combinational input-to-output path.
REQ-015 SHALL make the effect of an update visible on the outputs exactly 1 cycle after the edge at which upd_valid=1 is sampled.
REQ-016 SHALL declare a hit on entry i when vi=1 and Ai==upd_pc; if more than one entry hits, the lowest index SHALL win.
REQ-017 On a hit with upd_taken=1, SHALL increment si, saturating at 3, and SHALL load Bi with upd_target.
REQ-018 On a hit with upd_taken=0, SHALL decrement si, saturating at 0, and SHALL leave vi, Ai and Bi unchanged.
REQ-019 On a miss with upd_taken=1, SHALL allocate one entry and set v=1, A=upd_pc, B=upd_target, s=2'b10.
REQ-020 SHALL allocate to the lowest-index entry with v=0 when one exists.
REQ-021 When all 8 entries are valid, SHALL allocate to the entry selected by a 3-bit round-robin pointer (ptr value 0 selects entry 1), then advance ptr by 1 with wrap from 7 to 0 and increment evict_cnt.
REQ-022 SHALL leave ptr unchanged when allocating into an invalid entry.
REQ-023 On a miss with upd_taken=0, SHALL change no table state.
REQ-024 SHALL increment upd_cnt once for every update accepted under REQ-017..REQ-023.
REQ-025 SHALL wrap upd_cnt and evict_cnt from 0xFFFF to 0x0000.
REQ-026 With clr=1, SHALL clear v1..v8 and ptr to 0 on the next edge; A, B and s SHALL hold their values.
REQ-027 When clr=1 and upd_valid=1 in the same cycle, clr SHALL win: the update is dropped and upd_cnt does not increment.
REQ-028 When upd_valid=0, SHALL hold all state.
REQ-029 SHALL ignore upd_pc, upd_target and upd_taken while upd_valid=0.

Reset
REQ-030 When rst=1 at a clock edge, SHALL set v1..v8, A1..A8, B1..B8, s1..s8, ptr, upd_cnt and evict_cnt all to 0.
REQ-031 rst SHALL take priority over clr and upd_valid, including when asserted in the middle of an update sequence.
REQ-032 SHALL perform no reset action between clock edges.

Verification
REQ-033 Allocate from empty: after reset, apply upd pc=0x00000040, target=0x00000100, taken=1 -> next cycle v1=1, A1=0x40, B1=0x100, s1=2, upd_cnt=1, v2..v8=0.
REQ-034 Counter saturation: repeat REQ-033 update twice -> s1=3, then 3; apply same pc not-taken 4x -> s1=2,1,0,0; v1=1 and B1=0x100 throughout.
REQ-035 Replacement and wrap: allocate pcs 0x00,0x04..0x1C (all taken) -> v1..v8=1; then pc=0x20 taken -> A1=0x20, evict_cnt=1, ptr=1; 8 more new pcs -> ptr wraps to 1 and evict_cnt=9.
REQ-036 Miss not-taken: pc=0x80, taken=0 -> all table outputs unchanged, upd_cnt increments by 1.
REQ-037 Clear versus update: clr=1 together with upd_valid=1 (pc=0x90, taken=1) -> all v=0, ptr=0, no allocation, upd_cnt unchanged; next allocation goes to entry 1.
REQ-038 Reset mid-sequence: rst=1 on the same edge as an upd_valid=1 taken update -> all outputs 0 on the next cycle.
